div_ctrl: RTL and testbench

//  Sequencer between the EX stage and the iterative unsigned divider core (uint_diver).

---
 rtl/div_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_div_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Sequencer between the EX stage and the iterative unsigned divider core: converts signed
// operands to magnitudes, runs the core, fixes signs and returns a tagged result.
// Optional feature macro: DIV_SPECIAL_BYPASS_EN (divide-by-zero and MIN/-1 skip the core).
module div_ctrl #(
    parameter int DW      = 32,
    parameter int TAGW    = 5,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_signed,
    input  logic            req_rem,
    input  logic [DW-1:0]   req_a,
    input  logic [DW-1:0]   req_b,
    input  logic [TAGW-1:0] req_tag,
    input  logic            flush,
    output logic            stall,
    output logic            div_en,
    output logic [DW-1:0]   div_a,
    output logic [DW-1:0]   div_b,
    input  logic [DW-1:0]   div_q,
    input  logic [DW-1:0]   div_r,
    input  logic            div_end,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [DW-1:0]   resp_data,
    output logic [TAGW-1:0] resp_tag,
    output logic            timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WD_ONE  = CW'(1);
    localparam logic [DW-1:0] ONE     = DW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t          state_reg;
    logic [DW-1:0]   a_reg;
    logic [DW-1:0]   b_reg;
    logic            signed_reg;
    logic            rem_reg;
    logic [TAGW-1:0] tag_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic [DW-1:0]   q_raw_reg;
    logic [DW-1:0]   r_raw_reg;
    logic [CW-1:0]   wdog_reg;

    // Operand signs only matter for signed ops; unsigned ops pass straight through.
    logic          sa;
    logic          sb;
    logic [DW-1:0] a_mag;
    logic [DW-1:0] b_mag;
    logic [DW-1:0] q_fix;
    logic [DW-1:0] r_fix;

    assign sa    = signed_reg & a_reg[DW-1];
    assign sb    = signed_reg & b_reg[DW-1];
    assign a_mag = sa ? (~a_reg + ONE) : a_reg;
    assign b_mag = sb ? (~b_reg + ONE) : b_reg;
    assign q_fix = neg_q_reg ? (~q_raw_reg + ONE) : q_raw_reg;
    assign r_fix = neg_r_reg ? (~r_raw_reg + ONE) : r_raw_reg;

    logic          bypass_hit;
    logic [DW-1:0] bypass_q;
    logic [DW-1:0] bypass_r;

`ifdef DIV_SPECIAL_BYPASS_EN
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
    logic b_zero;
    logic ovf_case;

    // Results are fixed here, so the sign-fix stage is told to leave them alone.
    assign b_zero     = (b_reg == '0);
    assign ovf_case   = signed_reg && (a_reg == SMIN) && (b_reg == '1);
    assign bypass_hit = b_zero | ovf_case;
    assign bypass_q   = b_zero ? '1 : SMIN;
    assign bypass_r   = b_zero ? a_reg : '0;
`else
    assign bypass_hit = 1'b0;
    assign bypass_q   = '0;
    assign bypass_r   = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            req_ready   <= 1'b1;
            stall       <= 1'b0;
            div_en      <= 1'b0;
            div_a       <= '0;
            div_b       <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_tag    <= '0;
            timeout_err <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            signed_reg  <= 1'b0;
            rem_reg     <= 1'b0;
            tag_reg     <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            q_raw_reg   <= '0;
            r_raw_reg   <= '0;
            wdog_reg    <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        a_reg      <= req_a;
                        b_reg      <= req_b;
                        signed_reg <= req_signed;
                        rem_reg    <= req_rem;
                        tag_reg    <= req_tag;
                        req_ready  <= 1'b0;
                        stall      <= 1'b1;
                        state_reg  <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (flush) begin
                        state_reg <= ST_IDLE;
                        req_ready <= 1'b1;
                        stall     <= 1'b0;
                    end else begin
                        div_a <= a_mag;
                        div_b <= b_mag;
                        if (bypass_hit) begin
                            q_raw_reg <= bypass_q;
                            r_raw_reg <= bypass_r;
                            neg_q_reg <= 1'b0;
                            neg_r_reg <= 1'b0;
                            state_reg <= ST_FIX;
                        end else begin
                            neg_q_reg <= sa ^ sb;
                            neg_r_reg <= sa;
                            div_en    <= 1'b1;
                            wdog_reg  <= '0;
                            state_reg <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    // Flush outranks a completing core, which outranks the watchdog.
                    if (flush) begin
                        div_en    <= 1'b0;
                        state_reg <= ST_IDLE;
                        req_ready <= 1'b1;
                        stall     <= 1'b0;
                    end else if (div_end) begin
                        q_raw_reg <= div_q;
                        r_raw_reg <= div_r;
                        div_en    <= 1'b0;
                        state_reg <= ST_FIX;
                    end else if (wdog_reg == WD_LAST) begin
                        div_en      <= 1'b0;
                        timeout_err <= 1'b1;
                        resp_data   <= '1;
                        resp_tag    <= tag_reg;
                        resp_valid  <= 1'b1;
                        state_reg   <= ST_DONE;
                    end else begin
                        wdog_reg <= wdog_reg + WD_ONE;
                    end
                end

                ST_FIX: begin
                    if (flush) begin
                        state_reg <= ST_IDLE;
                        req_ready <= 1'b1;
                        stall     <= 1'b0;
                    end else begin
                        resp_data  <= rem_reg ? r_fix : q_fix;
                        resp_tag   <= tag_reg;
                        resp_valid <= 1'b1;
                        state_reg  <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (flush || resp_ready) begin
                        resp_valid <= 1'b0;
                        state_reg  <= ST_IDLE;
                        req_ready  <= 1'b1;
                        stall      <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                    div_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural 4-cycle divider core stand-in.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_signed, req_rem;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_tag;
    logic        flush, stall, div_en;
    logic [31:0] div_a, div_b, div_q, div_r;
    logic        div_end;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        timeout_err;

    int n_total = 0;
    int n_bad   = 0;

    logic       core_hang = 1'b0;
    logic [2:0] core_cnt;

    always #5 clk = ~clk;

    div_ctrl #(.DW(32), .TAGW(5), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
        .req_rem(req_rem), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .flush(flush), .stall(stall),
        .div_en(div_en), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r), .div_end(div_end),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag), .timeout_err(timeout_err)
    );

    // Core stand-in: raises div_end on the 4th cycle of div_en; divide-by-zero gives q=ones, r=a.
    always @(posedge clk) begin
        if (!div_en || core_hang) begin
            core_cnt <= 3'd0;
            div_end  <= 1'b0;
        end else if (core_cnt == 3'd3) begin
            div_end <= 1'b1;
            div_q   <= (div_b == 32'd0) ? 32'hFFFF_FFFF : div_a / div_b;
            div_r   <= (div_b == 32'd0) ? div_a : div_a % div_b;
        end else begin
            core_cnt <= core_cnt + 3'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request at a negedge and waits (bounded) for the response, then handshakes it.
    task automatic run_op(input logic sg, input logic rm, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tg, output logic [31:0] data, output logic [4:0] rtag,
                          output int lat, output logic en_seen, output logic to_seen);
        int guard;
        en_seen = 1'b0;
        to_seen = 1'b0;
        lat     = 0;
        data    = '0;
        rtag    = '0;
        guard   = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        req_valid  = 1'b1;
        req_signed = sg;
        req_rem    = rm;
        req_a      = a;
        req_b      = b;
        req_tag    = tg;
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_stall", {31'b0, stall}, 32'd1);
        check("busy_ready", {31'b0, req_ready}, 32'd0);
        while (!resp_valid && lat < 200) begin
            en_seen = en_seen | div_en;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("resp_wait", {31'b0, resp_valid}, 32'd1);
        data    = resp_data;
        rtag    = resp_tag;
        to_seen = timeout_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        $display("op signed=%0b rem=%0b a=0x%08h b=0x%08h tag=%0d -> data=0x%08h tag=%0d lat=%0d en=%0b to=%0b",
                 sg, rm, a, b, tg, data, rtag, lat, en_seen, to_seen);
    endtask

    logic [31:0] d;
    logic [4:0]  t;
    int          lat;
    logic        en_seen, to_seen;
    int          seen;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_rem = 1'b0;
        req_a = '0; req_b = '0; req_tag = '0; flush = 1'b0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_div_en", {31'b0, div_en}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_timeout", {31'b0, timeout_err}, 32'd0);
        check("rst_div_a", div_a, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_tag", {27'b0, resp_tag}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned quotient/remainder, latency = 4-cycle core + 3.
        run_op(1'b0, 1'b0, 32'd100, 32'd7, 5'd3, d, t, lat, en_seen, to_seen);
        check("divu_data", d, 32'd14);
        check("divu_tag", {27'b0, t}, 32'd3);
        check("divu_lat", lat, 32'd7);
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd4, d, t, lat, en_seen, to_seen);
        check("remu_data", d, 32'd2);
        check("remu_tag", {27'b0, t}, 32'd4);

        // Signed sign correction.
        run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd5, d, t, lat, en_seen, to_seen);
        check("div_neg7_2", d, 32'hFFFF_FFFD);
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd6, d, t, lat, en_seen, to_seen);
        check("rem_neg7_2", d, 32'hFFFF_FFFF);
        run_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 5'd7, d, t, lat, en_seen, to_seen);
        check("rem_7_neg2", d, 32'd1);
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 5'd8, d, t, lat, en_seen, to_seen);
        check("div_7_neg2", d, 32'hFFFF_FFFD);
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, d, t, lat, en_seen, to_seen);
        check("div_min_neg1", d, 32'h8000_0000);
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, d, t, lat, en_seen, to_seen);
        check("rem_min_neg1", d, 32'd0);

        // Divide by zero: bypassed in 2 cycles with the macro, otherwise through the core.
        run_op(1'b0, 1'b0, 32'd5, 32'd0, 5'd11, d, t, lat, en_seen, to_seen);
        check("divu_5_0", d, 32'hFFFF_FFFF);
`ifdef DIV_SPECIAL_BYPASS_EN
        check("bypass_en_seen", {31'b0, en_seen}, 32'd0);
        check("bypass_lat", lat, 32'd2);
`else
        check("div0_en_seen", {31'b0, en_seen}, 32'd1);
        check("div0_lat", lat, 32'd7);
`endif

        // Flush two cycles into RUN.
        req_valid = 1'b1; req_signed = 1'b0; req_rem = 1'b0;
        req_a = 32'd50; req_b = 32'd5; req_tag = 5'd12;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 0;
        while (!div_en && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        check("flush_run_entered", {31'b0, div_en}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_div_en", {31'b0, div_en}, 32'd0);
        check("flush_stall", {31'b0, stall}, 32'd0);
        check("flush_ready", {31'b0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        check("flush_no_resp", seen, 32'd0);
        $display("flush in RUN: div_en=%0b stall=%0b resp_valid_cycles=%0d", div_en, stall, seen);
        run_op(1'b0, 1'b0, 32'd100, 32'd7, 5'd13, d, t, lat, en_seen, to_seen);
        check("after_flush_data", d, 32'd14);
        check("after_flush_tag", {27'b0, t}, 32'd13);

        // Flush while the response is waiting in DONE.
        req_valid = 1'b1; req_signed = 1'b0; req_rem = 1'b0;
        req_a = 32'd9; req_b = 32'd3; req_tag = 5'd14;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 0;
        while (!resp_valid && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        check("done_resp", resp_data, 32'd3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("done_flush_valid", {31'b0, resp_valid}, 32'd0);
        check("done_flush_ready", {31'b0, req_ready}, 32'd1);
        $display("flush in DONE: resp_valid=%0b req_ready=%0b", resp_valid, req_ready);

        // Hung core: watchdog aborts after LOAD plus TIMEOUT cycles in RUN.
        core_hang = 1'b1;
        run_op(1'b0, 1'b0, 32'd100, 32'd7, 5'd15, d, t, lat, en_seen, to_seen);
        check("wd_data", d, 32'hFFFF_FFFF);
        check("wd_tag", {27'b0, t}, 32'd15);
        check("wd_pulse", {31'b0, to_seen}, 32'd1);
        check("wd_lat", lat, 32'd65);
        check("wd_pulse_len", {31'b0, timeout_err}, 32'd0);
        core_hang = 1'b0;

        // Reset asserted mid-RUN.
        req_valid = 1'b1; req_signed = 1'b1; req_rem = 1'b0;
        req_a = 32'd40; req_b = 32'd4; req_tag = 5'd16;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_run", {31'b0, div_en}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_ready", {31'b0, req_ready}, 32'd1);
        check("mrst_div_en", {31'b0, div_en}, 32'd0);
        check("mrst_stall", {31'b0, stall}, 32'd0);
        check("mrst_div_a", div_a, 32'd0);
        check("mrst_resp_data", resp_data, 32'd0);
        $display("reset mid RUN: req_ready=%0b div_en=%0b stall=%0b", req_ready, div_en, stall);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b1, 1'b0, 32'd40, 32'hFFFF_FFFC, 5'd17, d, t, lat, en_seen, to_seen);
        check("post_rst_data", d, 32'hFFFF_FFF6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
